multdiv_issue_ctrl: RTL and testbench
=====================================

# multdiv_issue_ctrl

Sequencing front-end that sits directly upstream of the multi-cycle multiplier and divider. It accepts one multiply or divide request from the execute stage and holds the operands stable for the whole operation. It fires the single-cycle start pulse, waits for the unit's ready strobe, then captures the result and exception and presents them to writeback through a valid/ready handshake. It also owns divide-by-zero short-circuiting, a watchdog timeout, and pipeline flush.

## Interface
Parameters:
- TIMEOUT, 40: maximum number of BUSY cycles before the watchdog forces completion.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and clears every register.
- in_valid  in  1  execute stage presents a request.
- in_ready  out  1  request is accepted on this edge; equals (state == IDLE).
- in_is_div  in  1  0 = multiply, 1 = divide.
- in_opA, in_opB  in  32  signed operands.
- in_rd  in  5  destination register tag, carried through unchanged.
- flush  in  1  abort the current operation; no writeback is produced.
- ctrl_MULT, ctrl_DIV  out  1  one-cycle start pulses to the arithmetic units.
- data_operandA, data_operandB  out  32  latched operands, stable from the ISSUE cycle until return to IDLE.
- data_result  in  32  unit result.
- data_exception  in  1  unit exception.
- data_resultRDY  in  1  unit completion strobe.
- wb_valid  out  1  result available.
- wb_ready  in  1  writeback consumes the result.
- wb_result  out  32  captured result.
- wb_exception  out  1  captured exception (unit, divide-by-zero, or timeout).
- wb_rd  out  5  captured destination tag.
- busy  out  1  (state != IDLE); drives the pipeline stall.

## Operation
- States: IDLE, ISSUE, BUSY, DONE. Encoded in 2 bits.
- IDLE, in_valid=1 (accept edge):
  - Latch opA, opB, is_div and rd.
  - If is_div=1 and opB=0: go directly to DONE with result=0, exception=1. No start pulse is issued.
  - Otherwise: go to ISSUE.
- ISSUE, one cycle only:
  - ctrl_DIV=1 if is_div, else ctrl_MULT=1; the other pulse stays 0.
  - data_resultRDY is ignored in this cycle, because the unit's counter is still being reset.
  - Clear the watchdog counter. Next state is BUSY.
- BUSY:
  - Watchdog increments each cycle.
  - data_resultRDY=1 at an edge: capture data_result and data_exception into the wb registers, go to DONE.
  - Watchdog reaches TIMEOUT-1 with no RDY: capture result=0, exception=1, go to DONE.
  - If RDY and timeout coincide, RDY wins and the unit's values are captured.
- DONE:
  - wb_valid=1, and the wb_* outputs are held stable.
  - wb_ready=1 at an edge: go to IDLE.
- flush=1 at any edge in ISSUE, BUSY or DONE:
  - Go to IDLE with no wb_valid pulse.
  - Flush takes priority over RDY, timeout and wb_ready.
  - Flush in IDLE also takes priority over in_valid: the request is not accepted.
- The operand registers hold their value after an operation completes; they are rewritten only at the next accept.
- Watchdog width is ceil(log2(TIMEOUT))+1 bits and saturates (does not wrap).

## Timing
- Reset values:
  - State IDLE, so in_ready=1 and busy=0.
  - ctrl_MULT=ctrl_DIV=0, wb_valid=0.
  - wb_result=0, wb_exception=0, wb_rd=0.
  - data_operandA=data_operandB=0; watchdog=0.
- Reset asserted mid-operation:
  - Immediate return to IDLE with all outputs at their reset values.
  - Any later RDY is ignored until the next ISSUE.
- Accept at edge T:
  - T+1: ISSUE, pulse high.
  - T+2: BUSY.
  - Unit RDY seen at edge T+1+N: wb_valid rises in the cycle after that edge.
- Divide-by-zero: wb_valid is high in cycle T+1.
- ctrl_MULT and ctrl_DIV are registered state decodes (state==ISSUE), glitch-free, and exactly one cycle wide.
- The earliest next accept is the edge after wb_ready. There is no back-to-back overlap.

## Test plan
- Multiply:
  - Stimulus: opA=7, opB=-3, rd=5; unit model returns RDY 17 cycles after the pulse with 0xFFFFFFEB and exc=0.
  - Required: ctrl_MULT high for exactly one cycle at T+1; operands stable throughout; wb_valid with 0xFFFFFFEB, exc=0, rd=5.
- Divide by zero:
  - Stimulus: is_div=1, opA=100, opB=0.
  - Required: no ctrl_DIV pulse; wb_valid at T+1 with result=0, exc=1.
- Timeout:
  - Stimulus: TIMEOUT=40; the unit never asserts RDY.
  - Required: wb_valid exactly 40 BUSY cycles after ISSUE, with result=0, exc=1.
- Flush:
  - Stimulus: flush in the BUSY cycle where RDY also fires; then a stray RDY arrives in IDLE.
  - Required: return to IDLE with no wb_valid; the stray RDY has no effect; the next request completes normally.
- Backpressure:
  - Stimulus: hold wb_ready=0 for 10 cycles in DONE.
  - Required: wb_result, wb_exception and wb_rd stay constant; in_ready stays 0 with in_valid held high; IDLE one edge after wb_ready=1.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously between edges while in BUSY.
  - Required: all outputs go to their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl: issue/sequencing front-end for the multi-cycle
// multiplier and divider. It latches one request, fires a one-cycle start
// pulse, waits for the unit's completion strobe (or the watchdog), and holds
// the captured result on a valid/ready writeback handshake.
module multdiv_issue_ctrl #(
    parameter int TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    // request from execute
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_div,
    input  logic [31:0] in_opA,
    input  logic [31:0] in_opB,
    input  logic [4:0]  in_rd,
    input  logic        flush,
    // arithmetic unit side
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] data_operandA,
    output logic [31:0] data_operandB,
    input  logic [31:0] data_result,
    input  logic        data_exception,
    input  logic        data_resultRDY,
    // writeback
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_result,
    output logic        wb_exception,
    output logic [4:0]  wb_rd,
    output logic        busy
);

    // One extra bit so TIMEOUT-1 always fits and saturation has headroom.
    localparam int WD_W = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [WD_W-1:0] wd_cnt;
    logic [4:0]      rd_q;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Single FSM: state, operand latches, start pulses, watchdog and wb capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            wd_cnt        <= '0;
            rd_q          <= '0;
            ctrl_MULT     <= 1'b0;
            ctrl_DIV      <= 1'b0;
            data_operandA <= '0;
            data_operandB <= '0;
            wb_valid      <= 1'b0;
            wb_result     <= '0;
            wb_exception  <= 1'b0;
            wb_rd         <= '0;
        end else begin
            // Start pulses are only ever set on the accept edge, so clearing
            // them by default makes them exactly one cycle wide.
            ctrl_MULT <= 1'b0;
            ctrl_DIV  <= 1'b0;
            if (flush) begin
                // Abort wins over everything, including a pending accept.
                state    <= IDLE;
                wb_valid <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (in_valid) begin
                            data_operandA <= in_opA;
                            data_operandB <= in_opB;
                            rd_q          <= in_rd;
                            if (in_is_div && (in_opB == 32'd0)) begin
                                // Divide-by-zero never reaches the unit.
                                wb_result    <= '0;
                                wb_exception <= 1'b1;
                                wb_rd        <= in_rd;
                                wb_valid     <= 1'b1;
                                state        <= DONE;
                            end else begin
                                ctrl_MULT <= ~in_is_div;
                                ctrl_DIV  <= in_is_div;
                                state     <= ISSUE;
                            end
                        end
                    end
                    ISSUE: begin
                        // RDY is ignored here: the unit is still resetting.
                        wd_cnt <= '0;
                        state  <= BUSY;
                    end
                    BUSY: begin
                        if (data_resultRDY) begin
                            wb_result    <= data_result;
                            wb_exception <= data_exception;
                            wb_rd        <= rd_q;
                            wb_valid     <= 1'b1;
                            state        <= DONE;
                        end else if (wd_cnt == WD_LAST) begin
                            wb_result    <= '0;
                            wb_exception <= 1'b1;
                            wb_rd        <= rd_q;
                            wb_valid     <= 1'b1;
                            state        <= DONE;
                        end else if (wd_cnt != '1) begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        if (wb_ready) begin
                            wb_valid <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Bench for multdiv_issue_ctrl: table of operations with expected writeback,
// a scoreboard queue of expected results, and hand-written flush/reset cases.
module tb_multdiv_issue_ctrl;

    localparam int TIMEOUT = 40;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_is_div, flush;
    logic [31:0] in_opA, in_opB;
    logic [4:0]  in_rd;
    logic        in_ready, ctrl_MULT, ctrl_DIV, busy;
    logic [31:0] data_operandA, data_operandB, data_result;
    logic        data_exception, data_resultRDY;
    logic        wb_valid, wb_ready, wb_exception;
    logic [31:0] wb_result;
    logic [4:0]  wb_rd;

    multdiv_issue_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_div(in_is_div),
        .in_opA(in_opA), .in_opB(in_opB), .in_rd(in_rd), .flush(flush),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .data_result(data_result), .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result),
        .wb_exception(wb_exception), .wb_rd(wb_rd), .busy(busy)
    );

    always #5 clock = ~clock;

    // One operation: inputs, unit behaviour, and required writeback.
    // lat = cycles after the pulse at which the unit RDY is sampled (-1: never).
    // edone = cycles after the accept edge at which wb_valid is first seen.
    typedef struct {
        logic        is_div;
        logic [31:0] a, b;
        logic [4:0]  rd;
        int          lat;
        logic [31:0] ures;
        logic        uexc;
        logic        rdy_in_issue;
        int          hold;
        logic [31:0] eres;
        logic        eexc;
        int          edone;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        logic [4:0]  rd;
    } sb_t;

    vec_t vecs[8];
    sb_t  sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic accept(input logic d, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        in_is_div = d; in_opA = a; in_opB = b; in_rd = rd; in_valid = 1'b1;
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_op(input vec_t v);
        int  done_k;
        sb_t e;
        data_result    = v.ures;
        data_exception = v.uexc;
        wb_ready       = 1'b0;
        accept(v.is_div, v.a, v.b, v.rd);
        sb.push_back('{res: v.eres, exc: v.eexc, rd: v.rd});
        done_k = -1;
        for (int k = 0; k <= TIMEOUT + 5; k++) begin
            chk("operandA_stable", data_operandA, v.a);
            chk("operandB_stable", data_operandB, v.b);
            if (k == 0) begin
                chk("ctrl_MULT_pulse", 32'(ctrl_MULT), 32'(!v.is_div && v.edone != 0));
                chk("ctrl_DIV_pulse", 32'(ctrl_DIV), 32'(v.is_div && v.edone != 0));
            end else begin
                chk("ctrl_MULT_low", 32'(ctrl_MULT), 32'd0);
                chk("ctrl_DIV_low", 32'(ctrl_DIV), 32'd0);
            end
            if (wb_valid) begin
                done_k = k;
                break;
            end
            data_resultRDY = (k == v.lat) || (k == 0 && v.rdy_in_issue);
            step();
        end
        data_resultRDY = 1'b0;
        chk("done_cycle", 32'(done_k), 32'(v.edone));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (wb_valid) begin
                chk("wb_result", wb_result, e.res);
                chk("wb_exception", 32'(wb_exception), 32'(e.exc));
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
            end
        end
        // Unit outputs change while DONE; captured values must not.
        data_result    = 32'hA5A5_A5A5;
        data_exception = ~v.eexc;
        if (v.hold > 0) begin
            in_valid = 1'b1; in_opA = 32'h0BAD_0BAD; in_is_div = 1'b0;
            for (int h = 0; h < v.hold; h++) begin
                step();
                chk("bp_wb_valid", 32'(wb_valid), 32'd1);
                chk("bp_wb_result", wb_result, v.eres);
                chk("bp_wb_exception", 32'(wb_exception), 32'(v.eexc));
                chk("bp_wb_rd", 32'(wb_rd), 32'(v.rd));
                chk("bp_in_ready", 32'(in_ready), 32'd0);
            end
            in_valid = 1'b0;
        end
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_wb_valid", 32'(wb_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("operandA_held", data_operandA, v.a);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ctrl"}, 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
        chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        chk({tag, "_wb_result"}, wb_result, 32'd0);
        chk({tag, "_wb_exception"}, 32'(wb_exception), 32'd0);
        chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
        chk({tag, "_opA"}, data_operandA, 32'd0);
        chk({tag, "_opB"}, data_operandB, 32'd0);
    endtask

    initial begin
        // is_div, a, b, rd, lat, ures, uexc, rdy_in_issue, hold, eres, eexc, edone
        vecs[0] = '{1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5, 17, 32'hFFFF_FFEB, 1'b0, 1'b0, 0,
                    32'hFFFF_FFEB, 1'b0, 18};
        vecs[1] = '{1'b1, 32'd100, 32'd0, 5'd3, -1, 32'hFFFF_FFFF, 1'b0, 1'b0, 0,
                    32'd0, 1'b1, 0};
        vecs[2] = '{1'b0, 32'd9, 32'd11, 5'd9, -1, 32'hCAFE_F00D, 1'b0, 1'b0, 0,
                    32'd0, 1'b1, TIMEOUT + 1};
        vecs[3] = '{1'b1, 32'd100, 32'd7, 5'd12, 5, 32'd14, 1'b0, 1'b0, 10,
                    32'd14, 1'b0, 6};
        vecs[4] = '{1'b1, 32'd50, 32'd2, 5'd20, TIMEOUT, 32'hDEAD_BEEF, 1'b0, 1'b0, 0,
                    32'hDEAD_BEEF, 1'b0, TIMEOUT + 1};
        vecs[5] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 1, 32'h1234_5678, 1'b1, 1'b1, 0,
                    32'h1234_5678, 1'b1, 2};
        vecs[6] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 3, 32'd1, 1'b0, 1'b1, 0,
                    32'd1, 1'b0, 4};
        vecs[7] = '{1'b0, 32'd123, 32'd0, 5'd7, 2, 32'd0, 1'b0, 1'b0, 0,
                    32'd0, 1'b0, 3};

        reset = 1'b1; in_valid = 1'b0; in_is_div = 1'b0; in_opA = '0; in_opB = '0;
        in_rd = '0; flush = 1'b0; data_result = '0; data_exception = 1'b0;
        data_resultRDY = 1'b0; wb_ready = 1'b0;
        #2;
        chk_reset_vals("por");
        #10 reset = 1'b0;
        step();

        foreach (vecs[i]) do_op(vecs[i]);

        // Flush in IDLE beats in_valid.
        in_is_div = 1'b0; in_opA = 32'd1; in_opB = 32'd2; in_valid = 1'b1; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_in_ready", 32'(in_ready), 32'd1);
        chk("flush_idle_no_pulse", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);

        // Flush in ISSUE.
        accept(1'b1, 32'd40, 32'd4, 5'd2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_issue_busy", 32'(busy), 32'd0);
        chk("flush_issue_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);

        // Flush coinciding with RDY in BUSY, then a stray RDY in IDLE.
        accept(1'b0, 32'd6, 32'd6, 5'd4);
        repeat (3) step();
        data_result = 32'h5555_5555; data_resultRDY = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy_in_ready", 32'(in_ready), 32'd1);
        chk("flush_busy_wb_valid", 32'(wb_valid), 32'd0);
        step();
        data_resultRDY = 1'b0;
        chk("stray_rdy_wb_valid", 32'(wb_valid), 32'd0);
        chk("stray_rdy_busy", 32'(busy), 32'd0);
        do_op(vecs[0]);

        // Asynchronous reset while BUSY, between clock edges.
        accept(1'b0, 32'h11, 32'h22, 5'd17);
        repeat (5) step();
        #3 reset = 1'b1;
        #1 chk_reset_vals("async_rst");
        #2 reset = 1'b0;
        step();
        data_resultRDY = 1'b1; data_result = 32'h7777_7777;
        step();
        data_resultRDY = 1'b0;
        chk("post_rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        do_op(vecs[3]);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
